// File: rtl/sync_fifo_flex.sv
// sync_fifo_flex
// Single-clock FIFO of arbitrary depth with standard or first-word-fall-through
// read mode, programmable almost-full/almost-empty thresholds, fill count,
// high-water mark and sticky overflow/underflow flags cleared by clr_err.

module sync_fifo_flex #(
  parameter int WIDTH     = 16,
  parameter int FIFO_SIZE = 16,
  parameter int AF_LEVEL  = 12,
  parameter int AE_LEVEL  = 2,
  parameter int FWFT      = 0,
  parameter int CNT_WIDTH = $clog2(FIFO_SIZE + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wr_en,
  input  logic [WIDTH-1:0]     wdata,
  input  logic                 rd_en,
  input  logic                 clr_err,
  output logic [WIDTH-1:0]     rdata,
  output logic                 rd_valid,
  output logic                 full,
  output logic                 empty,
  output logic                 almost_full,
  output logic                 almost_empty,
  output logic [CNT_WIDTH-1:0] count,
  output logic [CNT_WIDTH-1:0] hwm,
  output logic                 overflow,
  output logic                 underflow
);

  // Pointer width only needs to address FIFO_SIZE entries; wrap is by compare,
  // so non-power-of-two depths never touch unused addresses.
  localparam int PW = (FIFO_SIZE > 1) ? $clog2(FIFO_SIZE) : 1;

  localparam logic [PW-1:0]        LAST_PTR = PW'(FIFO_SIZE - 1);
  localparam logic [CNT_WIDTH-1:0] FULL_CNT = CNT_WIDTH'(FIFO_SIZE);
  localparam logic [CNT_WIDTH-1:0] AF_CNT   = CNT_WIDTH'(AF_LEVEL);
  localparam logic [CNT_WIDTH-1:0] AE_CNT   = CNT_WIDTH'(AE_LEVEL);

  logic [WIDTH-1:0]     mem [FIFO_SIZE];
  logic [PW-1:0]        wr_ptr;
  logic [PW-1:0]        rd_ptr;
  logic [PW-1:0]        wr_ptr_next;
  logic [PW-1:0]        rd_ptr_next;
  logic [CNT_WIDTH-1:0] count_next;
  logic [CNT_WIDTH-1:0] hwm_next;
  logic                 wr_ok;
  logic                 rd_ok;

  // Requests are qualified against the registered flags only, so a full FIFO
  // drops a write even when a read frees a slot in the same cycle (and the
  // mirror case for reads on an empty FIFO).
  assign wr_ok = wr_en & ~full;
  assign rd_ok = rd_en & ~empty;

  // Flags are a pure decode of the registered count, so they only move on
  // clock edges or reset.
  assign full         = (count == FULL_CNT);
  assign empty        = (count == '0);
  assign almost_full  = (count >= AF_CNT);
  assign almost_empty = (count <= AE_CNT);

  // Next-state values for pointers, count and high-water mark.
  always_comb begin
    wr_ptr_next = wr_ptr;
    rd_ptr_next = rd_ptr;
    count_next  = count;
    hwm_next    = hwm;

    if (wr_ok) begin
      wr_ptr_next = (wr_ptr == LAST_PTR) ? '0 : wr_ptr + 1'b1;
    end
    if (rd_ok) begin
      rd_ptr_next = (rd_ptr == LAST_PTR) ? '0 : rd_ptr + 1'b1;
    end

    case ({wr_ok, rd_ok})
      2'b10:   count_next = count + 1'b1;
      2'b01:   count_next = count - 1'b1;
      default: count_next = count;
    endcase

    if (clr_err) begin
      hwm_next = count_next;
    end else if (count_next > hwm) begin
      hwm_next = count_next;
    end
  end

  // Storage array is deliberately left without reset; count gates every read.
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem[wr_ptr] <= wdata;
    end
  end

  // Pointers, count, high-water mark and sticky error flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      hwm       <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      wr_ptr <= wr_ptr_next;
      rd_ptr <= rd_ptr_next;
      count  <= count_next;
      hwm    <= hwm_next;

      if (wr_en && full) begin
        overflow <= 1'b1;
      end else if (clr_err) begin
        overflow <= 1'b0;
      end

      if (rd_en && empty) begin
        underflow <= 1'b1;
      end else if (clr_err) begin
        underflow <= 1'b0;
      end
    end
  end

  generate
    if (FWFT != 0) begin : g_fwft
      // Head word is presented directly; a pop simply advances rd_ptr.
      assign rdata    = mem[rd_ptr];
      assign rd_valid = ~empty;
    end else begin : g_std
      logic [WIDTH-1:0] rdata_q;
      logic             rd_valid_q;

      // Registered read: data captured on an accepted read and held otherwise,
      // with a one-cycle valid strobe.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          rdata_q    <= '0;
          rd_valid_q <= 1'b0;
        end else begin
          rd_valid_q <= rd_ok;
          if (rd_ok) begin
            rdata_q <= mem[rd_ptr];
          end
        end
      end

      assign rdata    = rdata_q;
      assign rd_valid = rd_valid_q;
    end
  endgenerate

endmodule

// File: tb/tb_sync_fifo_flex.sv
// Testbench for sync_fifo_flex: table-driven vectors on a default instance,
// hand-written corner sequences, a randomized run against a queue model, and
// dedicated instances for a depth-6 FIFO and FWFT mode.

module tb_sync_fifo_flex;

  logic clk = 1'b0;
  logic rst = 1'b1;

  // Default instance (16 deep, standard read)
  logic        a_wr_en = 1'b0, a_rd_en = 1'b0, a_clr_err = 1'b0;
  logic [15:0] a_wdata = '0;
  logic [15:0] a_rdata;
  logic        a_rd_valid, a_full, a_empty, a_af, a_ae, a_ovf, a_unf;
  logic [4:0]  a_count, a_hwm;

  // Depth-6 instance (non-power-of-two wrap)
  logic        b_wr_en = 1'b0, b_rd_en = 1'b0, b_clr_err = 1'b0;
  logic [15:0] b_wdata = '0;
  logic [15:0] b_rdata;
  logic        b_rd_valid, b_full, b_empty, b_af, b_ae, b_ovf, b_unf;
  logic [2:0]  b_count, b_hwm;

  // FWFT instance
  logic        f_wr_en = 1'b0, f_rd_en = 1'b0, f_clr_err = 1'b0;
  logic [15:0] f_wdata = '0;
  logic [15:0] f_rdata;
  logic        f_rd_valid, f_full, f_empty, f_af, f_ae, f_ovf, f_unf;
  logic [4:0]  f_count, f_hwm;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  sync_fifo_flex dut (
    .clk(clk), .rst(rst), .wr_en(a_wr_en), .wdata(a_wdata), .rd_en(a_rd_en),
    .clr_err(a_clr_err), .rdata(a_rdata), .rd_valid(a_rd_valid), .full(a_full),
    .empty(a_empty), .almost_full(a_af), .almost_empty(a_ae), .count(a_count),
    .hwm(a_hwm), .overflow(a_ovf), .underflow(a_unf)
  );

  sync_fifo_flex #(.FIFO_SIZE(6), .AF_LEVEL(5), .AE_LEVEL(1)) dut6 (
    .clk(clk), .rst(rst), .wr_en(b_wr_en), .wdata(b_wdata), .rd_en(b_rd_en),
    .clr_err(b_clr_err), .rdata(b_rdata), .rd_valid(b_rd_valid), .full(b_full),
    .empty(b_empty), .almost_full(b_af), .almost_empty(b_ae), .count(b_count),
    .hwm(b_hwm), .overflow(b_ovf), .underflow(b_unf)
  );

  sync_fifo_flex #(.FWFT(1)) dutf (
    .clk(clk), .rst(rst), .wr_en(f_wr_en), .wdata(f_wdata), .rd_en(f_rd_en),
    .clr_err(f_clr_err), .rdata(f_rdata), .rd_valid(f_rd_valid), .full(f_full),
    .empty(f_empty), .almost_full(f_af), .almost_empty(f_ae), .count(f_count),
    .hwm(f_hwm), .overflow(f_ovf), .underflow(f_unf)
  );

  typedef struct {
    logic        wr;
    logic        rd;
    logic        clr;
    logic [15:0] wdata;
    logic [4:0]  e_count;
    logic [4:0]  e_hwm;
    logic        e_full;
    logic        e_empty;
    logic        e_af;
    logic        e_ae;
    logic        e_ovf;
    logic        e_unf;
    logic        e_rv;
    logic [15:0] e_rdata;
  } vec_t;

  vec_t vecs[$];

  // Watchdog so the run always ends even if something stalls.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic stepClock();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic wr, input logic rd, input logic clr,
                               input logic [15:0] data);
    a_wr_en   = wr;
    a_rd_en   = rd;
    a_clr_err = clr;
    a_wdata   = data;
    stepClock();
    a_wr_en   = 1'b0;
    a_rd_en   = 1'b0;
    a_clr_err = 1'b0;
  endtask

  function automatic vec_t makeVec(input logic wr, input logic rd, input logic clr,
                                   input logic [15:0] wdata, input int cnt,
                                   input int hw, input logic ovf, input logic unf,
                                   input logic rv, input logic [15:0] rdata);
    vec_t v;
    v.wr      = wr;
    v.rd      = rd;
    v.clr     = clr;
    v.wdata   = wdata;
    v.e_count = 5'(cnt);
    v.e_hwm   = 5'(hw);
    v.e_full  = (cnt == 16);
    v.e_empty = (cnt == 0);
    v.e_af    = (cnt >= 12);
    v.e_ae    = (cnt <= 2);
    v.e_ovf   = ovf;
    v.e_unf   = unf;
    v.e_rv    = rv;
    v.e_rdata = rdata;
    return v;
  endfunction

  task automatic checkDefault(input string tag, input int cnt, input int hw,
                              input logic ovf, input logic unf, input logic rv,
                              input logic [15:0] rdata);
    checkOutput({tag, ".count"}, 32'(a_count), 32'(cnt));
    checkOutput({tag, ".hwm"}, 32'(a_hwm), 32'(hw));
    checkOutput({tag, ".full"}, 32'(a_full), 32'(cnt == 16));
    checkOutput({tag, ".empty"}, 32'(a_empty), 32'(cnt == 0));
    checkOutput({tag, ".almost_full"}, 32'(a_af), 32'(cnt >= 12));
    checkOutput({tag, ".almost_empty"}, 32'(a_ae), 32'(cnt <= 2));
    checkOutput({tag, ".overflow"}, 32'(a_ovf), 32'(ovf));
    checkOutput({tag, ".underflow"}, 32'(a_unf), 32'(unf));
    checkOutput({tag, ".rd_valid"}, 32'(a_rd_valid), 32'(rv));
    checkOutput({tag, ".rdata"}, 32'(a_rdata), 32'(rdata));
  endtask

  initial begin
    int q_model[$];
    int m_hwm;
    logic m_ovf, m_unf, m_rv;
    logic [15:0] m_rdata;
    string tag;

    $display("[TB] start");

    // Reset values while rst is held
    repeat (2) @(posedge clk);
    #1;
    checkDefault("reset", 0, 0, 1'b0, 1'b0, 1'b0, 16'h0000);
    rst = 1'b0;

    // Vector table: fill, overflow, drain, underflow, clear
    for (int k = 1; k <= 16; k++)
      vecs.push_back(makeVec(1, 0, 0, 16'(k), k, k, 0, 0, 0, 16'h0000));
    vecs.push_back(makeVec(1, 0, 0, 16'hBEEF, 16, 16, 1, 0, 0, 16'h0000));
    for (int k = 1; k <= 16; k++)
      vecs.push_back(makeVec(0, 1, 0, 16'h0, 16 - k, 16, 1, 0, 1, 16'(k)));
    vecs.push_back(makeVec(0, 1, 0, 16'h0, 0, 16, 1, 1, 0, 16'h0010));
    vecs.push_back(makeVec(0, 0, 1, 16'h0, 0, 0, 0, 0, 0, 16'h0010));

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].wr, vecs[i].rd, vecs[i].clr, vecs[i].wdata);
      tag = $sformatf("vec%0d", i);
      checkOutput({tag, ".count"}, 32'(a_count), 32'(vecs[i].e_count));
      checkOutput({tag, ".hwm"}, 32'(a_hwm), 32'(vecs[i].e_hwm));
      checkOutput({tag, ".full"}, 32'(a_full), 32'(vecs[i].e_full));
      checkOutput({tag, ".empty"}, 32'(a_empty), 32'(vecs[i].e_empty));
      checkOutput({tag, ".almost_full"}, 32'(a_af), 32'(vecs[i].e_af));
      checkOutput({tag, ".almost_empty"}, 32'(a_ae), 32'(vecs[i].e_ae));
      checkOutput({tag, ".overflow"}, 32'(a_ovf), 32'(vecs[i].e_ovf));
      checkOutput({tag, ".underflow"}, 32'(a_unf), 32'(vecs[i].e_unf));
      checkOutput({tag, ".rd_valid"}, 32'(a_rd_valid), 32'(vecs[i].e_rv));
      checkOutput({tag, ".rdata"}, 32'(a_rdata), 32'(vecs[i].e_rdata));
    end

    // Full FIFO with simultaneous read+write: read wins, write dropped
    for (int i = 0; i < 16; i++) applyStimulus(1, 0, 0, 16'(16'h0100 + i));
    checkDefault("fill2", 16, 16, 1'b0, 1'b0, 1'b0, 16'h0010);
    applyStimulus(1, 1, 0, 16'hDEAD);
    checkDefault("full_rdwr", 15, 16, 1'b1, 1'b0, 1'b1, 16'h0100);
    applyStimulus(0, 0, 1, 16'h0);
    checkDefault("clr_after_full", 15, 15, 1'b0, 1'b0, 1'b0, 16'h0100);
    for (int i = 1; i <= 15; i++) begin
      applyStimulus(0, 1, 0, 16'h0);
      checkOutput($sformatf("drain%0d.rdata", i), 32'(a_rdata), 32'(16'h0100 + i));
      checkOutput($sformatf("drain%0d.count", i), 32'(a_count), 32'(15 - i));
    end
    checkOutput("drain.empty", 32'(a_empty), 32'd1);

    // Asynchronous reset mid-stream at count 9 with overflow set
    for (int i = 0; i < 16; i++) applyStimulus(1, 0, 0, 16'(16'h0200 + i));
    applyStimulus(1, 0, 0, 16'h1234);
    for (int i = 0; i < 7; i++) applyStimulus(0, 1, 0, 16'h0);
    checkOutput("pre_rst.count", 32'(a_count), 32'd9);
    checkOutput("pre_rst.overflow", 32'(a_ovf), 32'd1);
    #3;
    rst = 1'b1;
    #1;
    checkDefault("async_rst", 0, 0, 1'b0, 1'b0, 1'b0, 16'h0000);
    stepClock();
    rst = 1'b0;

    // Randomized run against a queue model
    m_hwm = 0; m_ovf = 0; m_unf = 0; m_rv = 0; m_rdata = '0;
    for (int c = 0; c < 600; c++) begin
      logic wr, rd, clr, in_full, in_empty;
      logic [15:0] d;
      int pw;
      pw  = (c < 200) ? 75 : ((c < 400) ? 50 : 25);
      wr  = ($urandom_range(99) < pw);
      rd  = ($urandom_range(99) < (100 - pw));
      clr = ($urandom_range(19) == 0);
      d   = 16'($urandom);
      in_full  = (q_model.size() == 16);
      in_empty = (q_model.size() == 0);
      m_rv = rd && !in_empty;
      if (m_rv) m_rdata = 16'(q_model.pop_front());
      if (wr && !in_full) q_model.push_back(int'(d));
      if (wr && in_full) m_ovf = 1'b1;
      else if (clr) m_ovf = 1'b0;
      if (rd && in_empty) m_unf = 1'b1;
      else if (clr) m_unf = 1'b0;
      if (clr) m_hwm = q_model.size();
      else if (q_model.size() > m_hwm) m_hwm = q_model.size();
      applyStimulus(wr, rd, clr, d);
      checkDefault($sformatf("rand%0d", c), q_model.size(), m_hwm, m_ovf, m_unf,
                   m_rv, m_rdata);
    end

    // Depth-6 streaming at count 3: pointers wrap repeatedly
    for (int i = 1; i <= 3; i++) begin
      b_wr_en = 1'b1; b_wdata = 16'(i);
      stepClock();
    end
    b_wr_en = 1'b0;
    checkOutput("d6.count_start", 32'(b_count), 32'd3);
    for (int i = 1; i <= 20; i++) begin
      b_wr_en = 1'b1; b_rd_en = 1'b1; b_wdata = 16'(i + 3);
      stepClock();
      checkOutput($sformatf("d6_pair%0d.rdata", i), 32'(b_rdata), 32'(i));
      checkOutput($sformatf("d6_pair%0d.rd_valid", i), 32'(b_rd_valid), 32'd1);
      checkOutput($sformatf("d6_pair%0d.count", i), 32'(b_count), 32'd3);
    end
    b_wr_en = 1'b0; b_rd_en = 1'b0;
    checkOutput("d6.hwm", 32'(b_hwm), 32'd3);
    checkOutput("d6.full", 32'(b_full), 32'd0);
    checkOutput("d6.almost_empty", 32'(b_ae), 32'd0);

    // FWFT: word visible one cycle after write, pops sustain one per cycle
    checkOutput("fwft.idle_valid", 32'(f_rd_valid), 32'd0);
    f_wr_en = 1'b1; f_wdata = 16'hA5A5;
    stepClock();
    f_wr_en = 1'b0;
    checkOutput("fwft.first_valid", 32'(f_rd_valid), 32'd1);
    checkOutput("fwft.first_rdata", 32'(f_rdata), 32'h0000A5A5);
    f_rd_en = 1'b1;
    stepClock();
    f_rd_en = 1'b0;
    checkOutput("fwft.pop_valid", 32'(f_rd_valid), 32'd0);
    checkOutput("fwft.pop_empty", 32'(f_empty), 32'd1);
    f_wr_en = 1'b1; f_wdata = 16'h00B1;
    stepClock();
    f_wdata = 16'h00B2;
    stepClock();
    f_wr_en = 1'b0;
    checkOutput("fwft.head_b1", 32'(f_rdata), 32'h000000B1);
    f_rd_en = 1'b1;
    stepClock();
    checkOutput("fwft.head_b2", 32'(f_rdata), 32'h000000B2);
    checkOutput("fwft.b2_valid", 32'(f_rd_valid), 32'd1);
    stepClock();
    f_rd_en = 1'b0;
    checkOutput("fwft.drained_valid", 32'(f_rd_valid), 32'd0);
    checkOutput("fwft.underflow", 32'(f_unf), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
